wb_initiator: RTL and testbench

Single-outstanding Wishbone classic-cycle initiator that drives the user-area slave port of the caravel user project from a simple valid/ready command interface. It lets a local sequencer, LA-driven test logic or a Honzales core issue 32-bit reads and writes to any Wishbone responder and get a response back. A cycle-count timeout retires transfers to slaves that never assert ack, such as a responder with ack tied low.

---
 rtl/wb_initiator.sv | 166 ++++++++++++++++
 tb/tb_wb_initiator.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_initiator.sv
// wb_initiator -- single-outstanding Wishbone classic-cycle initiator.
//
// Turns a valid/ready command into one Wishbone classic read or write cycle
// and returns a valid/ready response. Only one transfer is in flight at a
// time; throughput is at most one transfer every three cycles.
//
// Optional feature macro: WB_INITIATOR_TIMEOUT_EN
//   defined   : a bus-cycle counter aborts a transfer after TIMEOUT cycles
//               without ack and reports rsp_err=1.
//   undefined : no counter; BUS waits for ack indefinitely, rsp_err is 0.
//
// Parameters:
//   TIMEOUT    bus cycles to wait for ack before aborting (1..255)
//
// Ports:
//   wb_clk_i, wb_rst_ni         clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_we/adr/dat/sel          command fields (write flag, address, data, lanes)
//   rsp_valid/rsp_ready         response handshake
//   rsp_dat, rsp_err            read data (0 for writes/aborts), timeout flag
//   wbm_cyc_o/stb_o/we_o/sel_o/adr_o/dat_o   Wishbone initiator outputs
//   wbm_ack_i, wbm_dat_i        Wishbone responder acknowledge and read data
module wb_initiator #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  logic   ready_q;
  logic   accept;
  logic   expire;
  logic   cyc;
  logic   rvalid;

  // ready_q is a register so cmd_ready stays low while reset is held and
  // has no combinational dependence on cmd_valid.
  assign accept    = (state == IDLE) && cmd_valid && ready_q;
  assign cmd_ready = ready_q;
  assign wbm_cyc_o = cyc;
  assign wbm_stb_o = cyc;
  assign rsp_valid = rvalid;

`ifdef WB_INITIATOR_TIMEOUT_EN
  logic [7:0] cnt;
  logic       err_q;

  assign expire  = (cnt == 8'(TIMEOUT - 1));
  assign rsp_err = err_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (state == BUS && !wbm_ack_i) begin
      cnt <= cnt + 8'd1;
    end
  end

  // Ack is tested first so a coincident ack and expiry completes normally.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      err_q <= 1'b0;
    end else if (state == BUS) begin
      if (wbm_ack_i) begin
        err_q <= 1'b0;
      end else if (expire) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign expire  = 1'b0;
  assign rsp_err = 1'b0;
`endif

  // State register: asynchronous reset drops cyc/stb immediately since
  // they are decoded from state.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state   <= IDLE;
      ready_q <= 1'b0;
    end else begin
      state   <= state_next;
      ready_q <= (state_next == IDLE);
    end
  end

  always_comb begin
    state_next = state;
    cyc        = 1'b0;
    rvalid     = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_next = BUS;
      end
      BUS: begin
        cyc = 1'b1;
        if (wbm_ack_i || expire) state_next = RESP;
      end
      RESP: begin
        rvalid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Bus request fields are only loaded on accept, so they stay stable for
  // the whole cycle regardless of what the command port does afterwards.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
    end else if (accept) begin
      wbm_we_o  <= cmd_we;
      wbm_sel_o <= cmd_sel;
      wbm_adr_o <= cmd_adr;
      wbm_dat_o <= cmd_dat;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      rsp_dat <= '0;
    end else if (state == BUS) begin
      if (wbm_ack_i) begin
        rsp_dat <= wbm_we_o ? '0 : wbm_dat_i;
      end else if (expire) begin
        rsp_dat <= '0;
      end
    end
  end

endmodule

// File: tb/tb_wb_initiator.sv
`timescale 1ns/1ps
module tb_wb_initiator;

  localparam int unsigned TO = 4;
`ifdef WB_INITIATOR_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0;
  logic [31:0] cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack = 1'b0;
  logic [31:0] rdat = '0;

  int checks = 0;
  int errors = 0;

  wb_initiator #(.TIMEOUT(TO)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_adr   (cmd_adr),
    .cmd_dat   (cmd_dat),
    .cmd_sel   (cmd_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .wbm_cyc_o (cyc),
    .wbm_stb_o (stb),
    .wbm_we_o  (we),
    .wbm_sel_o (sel),
    .wbm_adr_o (adr),
    .wbm_dat_o (wdat),
    .wbm_ack_i (ack),
    .wbm_dat_i (rdat)
  );

  always #5 clk = ~clk;

  // One complete transfer: the responder acks in bus cycle index 'waits'
  // (if ack_en), the consumer stalls the response for 'hold' cycles.
  // Expectations follow directly from the transfer rules.
  task automatic xfer(input logic t_we, input logic [31:0] t_adr, input logic [31:0] t_dat,
                      input logic [3:0] t_sel, input bit ack_en, input int waits,
                      input int hold, input string tag);
    logic [31:0] rd;
    logic [31:0] exp_dat;
    int          exp_cycles;
    bit          exp_err;
    int          n;
    rd = $urandom;
    if (ack_en && (!TO_EN || waits < int'(TO))) begin
      exp_cycles = waits + 1;
      exp_err    = 1'b0;
    end else begin
      exp_cycles = int'(TO);
      exp_err    = 1'b1;
    end
    exp_dat = (!t_we && !exp_err) ? rd : 32'h0;

    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL %s idle_ready: got %b want 1", tag, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_we = t_we; cmd_adr = t_adr; cmd_dat = t_dat; cmd_sel = t_sel;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_we = ~t_we; cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = 4'($urandom);

    n = 0;
    while (cyc === 1'b1 && n < 600) begin
      checks++;
      if ({stb, we, sel, adr, wdat} !== {1'b1, t_we, t_sel, t_adr, t_dat}) begin
        errors++;
        $display("FAIL %s bus_fields cyc%0d: got stb=%b we=%b sel=%h adr=%h dat=%h want 1 %b %h %h %h",
                 tag, n, stb, we, sel, adr, wdat, t_we, t_sel, t_adr, t_dat);
      end
      checks++;
      if (cmd_ready !== 1'b0) begin
        errors++; $display("FAIL %s bus_ready: got %b want 0", tag, cmd_ready);
      end
      ack  = ack_en && (n == waits);
      rdat = (n == waits) ? rd : $urandom;
      n++;
      @(negedge clk);
    end
    ack = 1'b0;

    checks++;
    if (n != exp_cycles) begin
      errors++; $display("FAIL %s cyc_cycles: got %0d want %0d", tag, n, exp_cycles);
    end
    checks++;
    if ({rsp_valid, stb, cmd_ready} !== 3'b100) begin
      errors++; $display("FAIL %s resp_entry: got valid=%b stb=%b ready=%b want 1 0 0",
                         tag, rsp_valid, stb, cmd_ready);
    end
    checks++;
    if (rsp_dat !== exp_dat || rsp_err !== exp_err) begin
      errors++; $display("FAIL %s resp_data: got dat=%h err=%b want %h %b",
                         tag, rsp_dat, rsp_err, exp_dat, exp_err);
    end

    for (int i = 0; i < hold; i++) begin
      ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if ({rsp_valid, cyc, cmd_ready, rsp_err} !== {1'b1, 1'b0, 1'b0, exp_err} || rsp_dat !== exp_dat) begin
        errors++;
        $display("FAIL %s resp_hold%0d: got valid=%b cyc=%b ready=%b err=%b dat=%h want 1 0 0 %b %h",
                 tag, i, rsp_valid, cyc, cmd_ready, rsp_err, rsp_dat, exp_err, exp_dat);
      end
    end
    ack = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, cyc, cmd_ready} !== 3'b001) begin
      errors++; $display("FAIL %s resp_done: got valid=%b cyc=%b ready=%b want 0 0 1",
                         tag, rsp_valid, cyc, cmd_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, rsp_dat, rsp_err, cyc, stb, we, sel, adr, wdat} !== '0) begin
      errors++; $display("FAIL reset_outputs: got ready=%b valid=%b dat=%h err=%b cyc=%b adr=%h want all 0",
                         cmd_ready, rsp_valid, rsp_dat, rsp_err, cyc, adr);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, cyc} !== 3'b100) begin
      errors++; $display("FAIL reset_release: got ready=%b valid=%b cyc=%b want 1 0 0",
                         cmd_ready, rsp_valid, cyc);
    end
  endtask

  task automatic test_write_zero_wait();
    xfer(1'b1, 32'h3000_0000, 32'hDEAD_BEEF, 4'hF, 1'b1, 0, 0, "write0");
  endtask

  task automatic test_read_wait3();
    xfer(1'b0, 32'h3000_0010, 32'h0, 4'hF, 1'b1, 3, 0, "read3");
  endtask

  task automatic test_backpressure();
    xfer(1'b0, 32'h3000_0020, 32'h0, 4'h3, 1'b1, 1, 5, "backpressure");
  endtask

`ifdef WB_INITIATOR_TIMEOUT_EN
  task automatic test_timeout();
    xfer(1'b0, 32'h3000_0030, 32'h0, 4'hF, 1'b0, 0, 2, "timeout");
    ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, cyc} !== 2'b00) begin
        errors++; $display("FAIL late_ack%0d: got valid=%b cyc=%b want 0 0", i, rsp_valid, cyc);
      end
    end
    ack = 1'b0;
  endtask

  task automatic test_ack_at_timeout();
    xfer(1'b0, 32'h3000_0040, 32'h0, 4'hF, 1'b1, int'(TO) - 1, 0, "ack_at_timeout");
  endtask
`else
  task automatic test_no_timeout();
    xfer(1'b0, 32'h3000_0050, 32'h0, 4'hF, 1'b1, 40, 0, "long_wait");
  endtask
`endif

  task automatic test_bus_reset();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0060; cmd_dat = 32'h1; cmd_sel = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (cyc !== 1'b1) begin
      errors++; $display("FAIL bus_reset_start: got cyc=%b want 1", cyc);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cyc, stb, rsp_valid, cmd_ready} !== 4'b0000) begin
      errors++; $display("FAIL bus_reset_async: got cyc=%b stb=%b valid=%b ready=%b want 0 0 0 0",
                         cyc, stb, rsp_valid, cmd_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, cyc} !== 3'b100) begin
      errors++; $display("FAIL bus_reset_release: got ready=%b valid=%b cyc=%b want 1 0 0",
                         cmd_ready, rsp_valid, cyc);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      int  w;
      bit  en;
      w  = $urandom_range(0, 6);
      en = TO_EN ? ($urandom_range(0, 7) != 0) : 1'b1;
      xfer(1'($urandom), $urandom, $urandom, 4'($urandom), en, w,
           $urandom_range(0, 3), "random");
    end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait3();
    test_backpressure();
`ifdef WB_INITIATOR_TIMEOUT_EN
    test_timeout();
    test_ack_at_timeout();
`else
    test_no_timeout();
`endif
    test_bus_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
